// File: rtl/rbs_sub_seq_pkg.sv
// Shared definitions for the sequential ripple-borrow subtractor.
// Holds the FSM state encoding, the default operand/slice widths and a
// helper that sizes the slice-index register.
package rbs_sub_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SLICE = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Width of the slice index; at least one bit even for a single slice.
  function automatic int idx_width(input int nsl);
    return (nsl > 1) ? $clog2(nsl) : 1;
  endfunction

endpackage

// File: rtl/rbs_sub_seq_if.sv
// Operand/result handshake bundle for rbs_sub_seq.
//   in_valid/in_ready   : operand handshake (a, b, bin)
//   out_valid/out_ready : result handshake (d, bout, ovf)
// master = operand producer / result consumer, slave = the subtractor.
interface rbs_sub_seq_if
  import rbs_sub_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf
  );

endinterface

// File: rtl/rbs_sub_seq_sub_slice.sv
// Combinational SLICE-bit ripple-borrow subtractor built from a chain of
// full subtractors: {bout, d} = a - b - bin (unsigned).
//   bin  : borrow into bit 0
//   a, b : slice operands
//   d    : slice difference
//   bout : borrow out of the top bit
module rbs_sub_seq_sub_slice #(
  parameter int SLICE = 4
) (
  input  logic             bin,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic [SLICE:0] brw;

  assign brw[0] = bin;

  for (genvar gi = 0; gi < SLICE; gi++) begin : g_fs
    assign d[gi]       = a[gi] ^ b[gi] ^ brw[gi];
    // Borrow when b exceeds a, or they are equal and a borrow comes in.
    assign brw[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & brw[gi]);
  end

  assign bout = brw[SLICE];

endmodule

// File: rtl/rbs_sub_seq.sv
// Multi-cycle ripple-borrow subtractor: D = A - B - bin, one SLICE-bit
// slice per clock, low slice first. The borrow between slices lives in a
// register, so the combinational path is a single SLICE-bit borrow chain.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of rbs_sub_seq_if (operands in, result out)
// WIDTH must be a multiple of SLICE.
module rbs_sub_seq
  import rbs_sub_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic       clk,
  input  logic       rst,
  rbs_sub_seq_if.slave bus
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = idx_width(NSL);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);

  state_t           state_reg;
  logic [IW-1:0]    idx_reg;
  logic             borrow_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] d_reg;
  logic             bout_reg;
  logic             ovf_reg;
  logic             out_valid_reg;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE-1:0] d_slice;
  logic             bout_slice;

  // The single slice subtractor is time-multiplexed over the operands.
  assign a_slice = a_reg[idx_reg * SLICE +: SLICE];
  assign b_slice = b_reg[idx_reg * SLICE +: SLICE];

  rbs_sub_seq_sub_slice #(
    .SLICE (SLICE)
  ) u_sub_slice (
    .bin  (borrow_reg),
    .a    (a_slice),
    .b    (b_slice),
    .d    (d_slice),
    .bout (bout_slice)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      borrow_reg    <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      d_reg         <= '0;
      bout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            // Seeding the borrow register with bin makes slice 0 uniform.
            borrow_reg <= bus.bin;
            idx_reg    <= '0;
            state_reg  <= ST_CALC;
          end
        end
        ST_CALC: begin
          d_reg[idx_reg * SLICE +: SLICE] <= d_slice;
          borrow_reg <= bout_slice;
          idx_reg    <= idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) begin
            bout_reg <= bout_slice;
            // d's MSB is the top bit of the slice being written this cycle.
            ovf_reg  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                        (d_slice[SLICE-1] != a_reg[WIDTH-1]);
            out_valid_reg <= 1'b1;
            idx_reg       <= '0;
            state_reg     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Result held until taken; no new accept on the same edge.
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE) && !rst;
  assign bus.out_valid = out_valid_reg;
  assign bus.d         = d_reg;
  assign bus.bout      = bout_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_rbs_sub_seq.sv
// Directed self-checking bench for rbs_sub_seq (WIDTH=8, SLICE=4).
module tb_rbs_sub_seq;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  rbs_sub_seq_if #(.WIDTH(8)) bus_if ();

  rbs_sub_seq #(
    .WIDTH (8),
    .SLICE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation with out_ready=1 and returns the observed result,
  // accept-to-valid latency, and the handshake state one cycle later.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bout, output logic ovf,
                       output int lat, output logic rdy_after, output logic vld_after);
    int w;
    w = 0;
    bus_if.out_ready = 1'b1;
    while (!bus_if.in_ready && w < 20) begin
      tick();
      w++;
    end
    bus_if.a = a;
    bus_if.b = b;
    bus_if.bin = bin;
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    lat = 0;
    while (!bus_if.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    d = bus_if.d;
    bout = bus_if.bout;
    ovf = bus_if.ovf;
    $display("[TB] op a=%02h b=%02h bin=%0d -> d=%02h bout=%0d ovf=%0d lat=%0d",
             a, b, bin, d, bout, ovf, lat);
    tick();
    rdy_after = bus_if.in_ready;
    vld_after = bus_if.out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus_if.in_ready !== 1'b0) begin
      $display("FAIL reset_in_ready: got %0b, expected 0", bus_if.in_ready);
      tests_failed++;
    end
    tests_run++;
    if ({bus_if.out_valid, bus_if.d, bus_if.bout, bus_if.ovf} !== 11'd0) begin
      $display("FAIL reset_outputs: got vld=%0b d=%02h bout=%0b ovf=%0b, expected all 0",
               bus_if.out_valid, bus_if.d, bus_if.bout, bus_if.ovf);
      tests_failed++;
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (bus_if.in_ready !== 1'b1) begin
      $display("FAIL reset_release_in_ready: got %0b, expected 1", bus_if.in_ready);
      tests_failed++;
    end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic bout, ovf, ra, va;
    int lat;
    do_op(8'h50, 8'h23, 1'b0, d, bout, ovf, lat, ra, va);
    tests_run++;
    if (lat !== 2) begin
      $display("FAIL basic_latency: got %0d, expected 2", lat);
      tests_failed++;
    end
    tests_run++;
    if ({d, bout, ovf} !== {8'h2D, 1'b0, 1'b0}) begin
      $display("FAIL basic_result: got d=%02h bout=%0b ovf=%0b, expected d=2d bout=0 ovf=0", d, bout, ovf);
      tests_failed++;
    end
    tests_run++;
    if ({ra, va} !== 2'b10) begin
      $display("FAIL basic_handshake_after: got in_ready=%0b out_valid=%0b, expected 1 0", ra, va);
      tests_failed++;
    end
  endtask

  task automatic test_borrow_chain();
    logic [7:0] d;
    logic bout, ovf, ra, va;
    int lat;
    do_op(8'h10, 8'h01, 1'b0, d, bout, ovf, lat, ra, va);
    tests_run++;
    if ({d, bout, ovf} !== {8'h0F, 1'b0, 1'b0}) begin
      $display("FAIL borrow_chain: got d=%02h bout=%0b ovf=%0b, expected d=0f bout=0 ovf=0", d, bout, ovf);
      tests_failed++;
    end
  endtask

  task automatic test_edges();
    logic [7:0] d;
    logic bout, ovf, ra, va;
    int lat;
    do_op(8'h00, 8'h00, 1'b1, d, bout, ovf, lat, ra, va);
    tests_run++;
    if ({d, bout, ovf} !== {8'hFF, 1'b1, 1'b0}) begin
      $display("FAIL edge_bin_underflow: got d=%02h bout=%0b ovf=%0b, expected d=ff bout=1 ovf=0", d, bout, ovf);
      tests_failed++;
    end
    do_op(8'h80, 8'h01, 1'b0, d, bout, ovf, lat, ra, va);
    tests_run++;
    if ({d, bout, ovf} !== {8'h7F, 1'b0, 1'b1}) begin
      $display("FAIL edge_neg_ovf: got d=%02h bout=%0b ovf=%0b, expected d=7f bout=0 ovf=1", d, bout, ovf);
      tests_failed++;
    end
    do_op(8'h7F, 8'hFF, 1'b0, d, bout, ovf, lat, ra, va);
    tests_run++;
    if ({d, bout, ovf} !== {8'h80, 1'b1, 1'b1}) begin
      $display("FAIL edge_pos_ovf: got d=%02h bout=%0b ovf=%0b, expected d=80 bout=1 ovf=1", d, bout, ovf);
      tests_failed++;
    end
  endtask

  task automatic test_backpressure();
    int w;
    bus_if.out_ready = 1'b0;
    bus_if.a = 8'h9A;
    bus_if.b = 8'h45;
    bus_if.bin = 1'b0;
    bus_if.in_valid = 1'b1;
    w = 0;
    while (!bus_if.in_ready && w < 20) begin
      tick();
      w++;
    end
    tick();
    // Different operands stay offered; they must not be captured yet.
    bus_if.a = 8'h11;
    bus_if.b = 8'h22;
    w = 0;
    while (!bus_if.out_valid && w < 20) begin
      tick();
      w++;
    end
    tests_run++;
    if ({bus_if.d, bus_if.bout, bus_if.ovf} !== {8'h55, 1'b0, 1'b1}) begin
      $display("FAIL bp_result: got d=%02h bout=%0b ovf=%0b, expected d=55 bout=0 ovf=1",
               bus_if.d, bus_if.bout, bus_if.ovf);
      tests_failed++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if ({bus_if.out_valid, bus_if.in_ready, bus_if.d} !== {1'b1, 1'b0, 8'h55}) begin
        $display("FAIL bp_hold cycle %0d: got vld=%0b rdy=%0b d=%02h, expected vld=1 rdy=0 d=55",
                 i, bus_if.out_valid, bus_if.in_ready, bus_if.d);
        tests_failed++;
      end
    end
    bus_if.out_ready = 1'b1;
    tick();
    tests_run++;
    if ({bus_if.out_valid, bus_if.in_ready} !== 2'b01) begin
      $display("FAIL bp_release: got vld=%0b rdy=%0b, expected vld=0 rdy=1",
               bus_if.out_valid, bus_if.in_ready);
      tests_failed++;
    end
    tick();
    bus_if.in_valid = 1'b0;
    w = 0;
    while (!bus_if.out_valid && w < 20) begin
      tick();
      w++;
    end
    tests_run++;
    if ({bus_if.out_valid, bus_if.d, bus_if.bout, bus_if.ovf} !== {1'b1, 8'hEF, 1'b1, 1'b0}) begin
      $display("FAIL bp_second_op: got vld=%0b d=%02h bout=%0b ovf=%0b, expected vld=1 d=ef bout=1 ovf=0",
               bus_if.out_valid, bus_if.d, bus_if.bout, bus_if.ovf);
      tests_failed++;
    end
    $display("[TB] backpressure second op a=11 b=22 -> d=%02h", bus_if.d);
    tick();
  endtask

  task automatic test_reset_mid_calc();
    logic [7:0] d;
    logic bout, ovf, ra, va, seen;
    int lat;
    int w;
    bus_if.out_ready = 1'b1;
    w = 0;
    while (!bus_if.in_ready && w < 20) begin
      tick();
      w++;
    end
    bus_if.a = 8'hFF;
    bus_if.b = 8'h01;
    bus_if.bin = 1'b0;
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tests_run++;
    if ({bus_if.out_valid, bus_if.d, bus_if.bout, bus_if.ovf, bus_if.in_ready} !== 12'd0) begin
      $display("FAIL midrst_outputs: got vld=%0b d=%02h bout=%0b ovf=%0b rdy=%0b, expected all 0",
               bus_if.out_valid, bus_if.d, bus_if.bout, bus_if.ovf, bus_if.in_ready);
      tests_failed++;
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus_if.out_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      $display("FAIL midrst_no_result: got out_valid seen=%0b, expected 0", seen);
      tests_failed++;
    end
    do_op(8'h03, 8'h05, 1'b0, d, bout, ovf, lat, ra, va);
    tests_run++;
    if ({d, bout, ovf} !== {8'hFE, 1'b1, 1'b0}) begin
      $display("FAIL midrst_next_op: got d=%02h bout=%0b ovf=%0b, expected d=fe bout=1 ovf=0", d, bout, ovf);
      tests_failed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] op_a [16];
    logic [7:0] op_b [16];
    logic       op_c [16];
    logic [8:0] ref_full;
    logic       ref_ovf;
    logic       acc;
    int k, r, cyc, last_acc;
    for (int i = 0; i < 16; i++) begin
      op_a[i] = 8'($urandom_range(0, 255));
      op_b[i] = 8'($urandom_range(0, 255));
      op_c[i] = 1'($urandom_range(0, 1));
    end
    k = 0;
    r = 0;
    cyc = 0;
    last_acc = 0;
    bus_if.out_ready = 1'b1;
    bus_if.a = op_a[0];
    bus_if.b = op_b[0];
    bus_if.bin = op_c[0];
    bus_if.in_valid = 1'b1;
    while (r < 16 && cyc < 200) begin
      acc = bus_if.in_ready && bus_if.in_valid;
      tick();
      cyc++;
      if (acc) begin
        if (k > 0) begin
          tests_run++;
          if (cyc - last_acc !== 4) begin
            $display("FAIL b2b_interval op %0d: got %0d cycles, expected 4", k, cyc - last_acc);
            tests_failed++;
          end
        end
        last_acc = cyc;
        k++;
        if (k < 16) begin
          bus_if.a = op_a[k];
          bus_if.b = op_b[k];
          bus_if.bin = op_c[k];
        end else begin
          bus_if.in_valid = 1'b0;
        end
      end
      if (bus_if.out_valid) begin
        ref_full = {1'b0, op_a[r]} - {1'b0, op_b[r]} - {8'd0, op_c[r]};
        ref_ovf = (op_a[r][7] != op_b[r][7]) && (ref_full[7] != op_a[r][7]);
        $display("[TB] b2b op %0d a=%02h b=%02h bin=%0d -> d=%02h bout=%0b ovf=%0b",
                 r, op_a[r], op_b[r], op_c[r], bus_if.d, bus_if.bout, bus_if.ovf);
        tests_run++;
        if ({bus_if.bout, bus_if.d, bus_if.ovf} !== {ref_full, ref_ovf}) begin
          $display("FAIL b2b_result op %0d: got d=%02h bout=%0b ovf=%0b, expected d=%02h bout=%0b ovf=%0b",
                   r, bus_if.d, bus_if.bout, bus_if.ovf, ref_full[7:0], ref_full[8], ref_ovf);
          tests_failed++;
        end
        r++;
      end
    end
    bus_if.in_valid = 1'b0;
    tests_run++;
    if (r !== 16) begin
      $display("FAIL b2b_count: got %0d results, expected 16", r);
      tests_failed++;
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.a = '0;
    bus_if.b = '0;
    bus_if.bin = 1'b0;
    bus_if.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_borrow_chain();
    test_edges();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
